// File: rtl/timer_pkg.sv
// timer_pkg: shared digit type, state encoding and seconds limits for the timer
package timer_pkg;
    typedef logic [3:0] bcd_t;
    typedef enum logic [1:0] {HOLD, SET, RUN, EXPIRED} state_t;
    localparam bcd_t SEC_MAX_TENS = 4'd5;
    localparam bcd_t SEC_MAX_ONES = 4'd9;
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter, increment wraps max->00, decrement wraps 00->max
module bcd2_counter
    import timer_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_dec,
    output bcd_t o_ones,
    output bcd_t o_tens,
    output logic o_borrow
);
    localparam bcd_t MAX_TENS = bcd_t'((MOD - 1) / 10);
    localparam bcd_t MAX_ONES = bcd_t'((MOD - 1) % 10);
    bcd_t r_ones, r_tens;
    logic w_at_max;
    assign w_at_max = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    assign o_borrow = (r_tens == '0) && (r_ones == '0);
    assign o_ones = r_ones;
    assign o_tens = r_tens;
    // ones digit rolls 9<->0 and carries/borrows into tens; whole value wraps at the modulus
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (i_inc) begin
            r_ones <= (w_at_max || r_ones == 4'd9) ? '0 : r_ones + 4'd1;
            r_tens <= w_at_max ? '0 : (r_ones == 4'd9) ? r_tens + 4'd1 : r_tens;
        end else if (i_dec) begin
            r_ones <= o_borrow ? MAX_ONES : (r_ones == '0) ? 4'd9 : r_ones - 4'd1;
            r_tens <= o_borrow ? MAX_TENS : (r_ones == '0) ? r_tens - 4'd1 : r_tens;
        end
    end
endmodule

// File: rtl/timer_count_controller.sv
// timer_count_controller: min:sec BCD set/countdown sequencer with 1 Hz prescaler and alarm timing
module timer_count_controller
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int ALARM_TICKS = 5,
    parameter int MAX_MIN     = 99
) (
    input  logic clk,
    input  logic reset,
    input  logic enableCounter,
    input  logic forward,
    input  logic resetTimer,
    input  logic segDemand,
    input  logic minDemand,
    output bcd_t sec_ones,
    output bcd_t sec_tens,
    output bcd_t min_ones,
    output bcd_t min_tens,
    output logic tick,
    output logic done,
    output logic alarm,
    output logic running
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] A_LAST = AW'(ALARM_TICKS - 1);
    state_t r_state, w_mode;
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_acnt;
    logic r_seg_q, r_min_q, r_tick, r_done, r_alarm, r_running;
    logic w_ptc, w_sec_inc, w_min_inc, w_sec_dec, w_min_dec, w_sec_zero, w_min_zero, w_expire;
    assign w_mode    = !enableCounter ? HOLD : (forward ? SET : RUN);
    assign w_ptc     = r_presc == P_LAST;
    assign w_sec_inc = r_state == SET && segDemand && !r_seg_q;
    assign w_min_inc = r_state == SET && minDemand && !r_min_q;
    assign w_sec_dec = r_state == RUN && w_ptc && !(w_sec_zero && w_min_zero);
    assign w_min_dec = w_sec_dec && w_sec_zero;
    assign w_expire  = w_sec_dec && w_min_zero && sec_tens == '0 && sec_ones == 4'd1;
    assign tick      = r_tick;
    assign done      = r_done;
    assign alarm     = r_alarm;
    assign running   = r_running;
    bcd2_counter #(.MOD(SEC_MAX_TENS * 10 + SEC_MAX_ONES + 1)) u_sec (
        .clk(clk), .reset(reset), .i_clr(resetTimer), .i_inc(w_sec_inc), .i_dec(w_sec_dec),
        .o_ones(sec_ones), .o_tens(sec_tens), .o_borrow(w_sec_zero)
    );
    bcd2_counter #(.MOD(MAX_MIN + 1)) u_min (
        .clk(clk), .reset(reset), .i_clr(resetTimer), .i_inc(w_min_inc), .i_dec(w_min_dec),
        .o_ones(min_ones), .o_tens(min_tens), .o_borrow(w_min_zero)
    );
    // button history sampled every cycle so a held button never counts on entering SET
    always_ff @(posedge clk) begin
        r_seg_q <= reset ? 1'b0 : segDemand;
        r_min_q <= reset ? 1'b0 : minDemand;
    end
    // prescaler: zeroed in SET, frozen in HOLD so a pause keeps the fractional second
    always_ff @(posedge clk) begin
        if (reset || resetTimer || r_state == SET)
            r_presc <= '0;
        else if (r_state == RUN || r_state == EXPIRED)
            r_presc <= w_ptc ? '0 : r_presc + 1'b1;
    end
    // mode FSM with registered tick/done/alarm/running; EXPIRED ignores the control strobes
    always_ff @(posedge clk) begin
        if (reset || resetTimer) begin
            r_state   <= HOLD;
            r_acnt    <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
            r_alarm   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tick <= r_state == RUN && w_ptc;
            r_done <= w_expire;
            if (r_state == EXPIRED) begin
                r_running <= 1'b0;
                if (w_ptc) begin
                    r_acnt <= r_acnt + 1'b1;
                    if (r_acnt == A_LAST) begin
                        r_state <= HOLD;
                        r_alarm <= 1'b0;
                    end
                end
            end else if (w_expire) begin
                r_state   <= EXPIRED;
                r_alarm   <= 1'b1;
                r_acnt    <= '0;
                r_running <= 1'b0;
            end else begin
                r_state   <= w_mode;
                r_running <= w_mode == RUN;
            end
        end
    end
endmodule
